// File: rtl/ram_master_ctrl_if.sv
// CPU burst request/response channel plus RAM strobe port of the RAM initiator.
// Modport master is the controller's view; slave is the CPU + RAM side.
interface ram_master_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wdata_valid;
    logic [DATA_W-1:0] wdata;
    logic              wdata_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              busy;
    logic              ram_read_en;
    logic              ram_write_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport master (
        input  req_valid, req_write, req_addr, req_len, wdata_valid, wdata, ram_dout,
        output req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, busy,
        output ram_read_en, ram_write_en, ram_addr, ram_din
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, wdata_valid, wdata, ram_dout,
        input  req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, busy,
        input  ram_read_en, ram_write_en, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_master_ctrl.sv
// Burst RAM initiator: read data returns 2 cycles after accept, one beat per cycle, no rsp backpressure.
// Requests stall while busy; write beats stall on wdata_valid without losing a beat.
module ram_master_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_master_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, RD_DRAIN, WR} state_t;

    localparam logic [LEN_W:0]    CNT_ONE  = (LEN_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W:0]    r_cnt;
    logic              r_iss_last;
    logic              r_pend;
    logic              r_pend_last;
    logic              r_req_ready;
    logic              r_wdata_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_last;
    logic              r_busy;
    logic              r_ram_read_en;
    logic              r_ram_write_en;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;

    logic w_req_acc;
    logic w_wr_hs;

    assign w_req_acc = bus.req_valid && r_req_ready;
    assign w_wr_hs   = bus.wdata_valid && r_wdata_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_addr         <= '0;
            r_cnt          <= '0;
            r_iss_last     <= 1'b0;
            r_pend         <= 1'b0;
            r_pend_last    <= 1'b0;
            r_req_ready    <= 1'b1;
            r_wdata_ready  <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_last     <= 1'b0;
            r_busy         <= 1'b0;
            r_ram_read_en  <= 1'b0;
            r_ram_write_en <= 1'b0;
            r_ram_addr     <= '0;
            r_ram_din      <= '0;
        end else begin
            // RAM registers dout on the edge after the strobe; capture it one edge later
            r_pend      <= r_ram_read_en;
            r_pend_last <= r_ram_read_en && r_iss_last;
            r_rsp_valid <= r_pend;
            r_rsp_last  <= r_pend_last;
            if (r_pend) begin
                r_rsp_data <= bus.ram_dout;
            end
            r_ram_read_en  <= 1'b0;
            r_ram_write_en <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_req_acc) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (bus.req_write) begin
                            r_state       <= WR;
                            r_wdata_ready <= 1'b1;
                            r_addr        <= bus.req_addr;
                            r_cnt         <= {1'b0, bus.req_len} + CNT_ONE;
                        end else begin
                            // first beat issues on the accept edge; r_cnt counts beats still to issue
                            r_state       <= RD;
                            r_ram_read_en <= 1'b1;
                            r_ram_addr    <= bus.req_addr;
                            r_addr        <= bus.req_addr + ADDR_ONE;
                            r_cnt         <= {1'b0, bus.req_len};
                            r_iss_last    <= (bus.req_len == '0);
                        end
                    end
                end
                RD: begin
                    if (r_cnt != '0) begin
                        r_ram_read_en <= 1'b1;
                        r_ram_addr    <= r_addr;
                        r_addr        <= r_addr + ADDR_ONE;
                        r_cnt         <= r_cnt - CNT_ONE;
                        r_iss_last    <= (r_cnt == CNT_ONE);
                    end else begin
                        r_state <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (r_rsp_last) begin
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                WR: begin
                    if (w_wr_hs) begin
                        r_ram_write_en <= 1'b1;
                        r_ram_din      <= bus.wdata;
                        r_ram_addr     <= r_addr;
                        r_addr         <= r_addr + ADDR_ONE;
                        r_cnt          <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_state       <= IDLE;
                            r_wdata_ready <= 1'b0;
                            r_req_ready   <= 1'b1;
                            r_busy        <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.wdata_ready  = r_wdata_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_last     = r_rsp_last;
    assign bus.busy         = r_busy;
    assign bus.ram_read_en  = r_ram_read_en;
    assign bus.ram_write_en = r_ram_write_en;
    assign bus.ram_addr     = r_ram_addr;
    assign bus.ram_din      = r_ram_din;
endmodule
